// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Feeds the ALU from the host. Host commands are buffered in a small FIFO
// (valid/ready) and issued one at a time as a single-cycle pulse on the ALU
// pins. An optional number of idle cycles can follow each issue. An ALU
// interrupt freezes issuing (HOLD) until the host acknowledges it.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   GAP    idle cycles inserted after every issue (0..15)
//   CNT_W  width of issue_cnt
//
// Ports
//   alu_clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready          host handshake (cmd_ready = FIFO not full)
//   cmd_unit, cmd_op, cmd_a,
//   cmd_b, cmd_clr               host command fields
//   alu_enable, alu_enable_a/b   registered one-cycle issue strobes
//   alu_op_a/b, alu_in_a/b       registered op/operands, held between issues
//   alu_irq_clr                  cmd_clr of the issuing command
//   alu_irq, irq_ack             ALU interrupt in, host acknowledge in
//   irq_pending                  high while frozen in HOLD
//   fifo_level, issue_cnt        queued entries, issued commands (wrapping)
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int GAP   = 0,
    parameter int CNT_W = 8
) (
    input  logic                     alu_clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_unit,
    input  logic [1:0]               cmd_op,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic                     cmd_clr,
    output logic                     alu_enable,
    output logic                     alu_enable_a,
    output logic                     alu_enable_b,
    output logic [1:0]               alu_op_a,
    output logic [1:0]               alu_op_b,
    output logic [7:0]               alu_in_a,
    output logic [7:0]               alu_in_b,
    output logic                     alu_irq_clr,
    input  logic                     alu_irq,
    input  logic                     irq_ack,
    output logic                     irq_pending,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         issue_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = 20;
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    // The gap counter is loaded with GAP-1 so that the GAP state lasts GAP cycles.
    localparam logic [3:0] GAP_LOAD = 4'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_HOLD
    } state_t;

    // ---------------- FIFO ----------------
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full      = (level_reg == FULL_LEVEL);
    assign empty     = (level_reg == '0);
    assign cmd_ready = !full;
    // Acceptance is gated by full from the start of the cycle, so a
    // simultaneous pop never lets a push into a full FIFO.
    assign push      = cmd_valid && !full;

    always_ff @(posedge alu_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd_unit, cmd_op, cmd_a, cmd_b, cmd_clr};
        end
    end

    always_ff @(posedge alu_clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !push) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

    logic [DW-1:0] head;
    logic          head_unit;
    logic [1:0]    head_op;
    logic [7:0]    head_a;
    logic [7:0]    head_b;
    logic          head_clr;

    assign head = mem[rd_ptr_reg];
    assign {head_unit, head_op, head_a, head_b, head_clr} = head;

    // ---------------- FSM ----------------
    state_t     state_reg;
    state_t     state_next;
    logic [3:0] gap_reg;
    logic [3:0] gap_next;

    always_ff @(posedge alu_clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        pop        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (alu_irq) begin
                    state_next = S_HOLD;
                end else if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (alu_irq) begin
                    state_next = S_HOLD;
                end else if (GAP > 0) begin
                    state_next = S_GAP;
                    gap_next   = GAP_LOAD;
                end else if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_GAP: begin
                // The last gap edge makes the IDLE decision directly, so
                // issues are spaced exactly GAP+1 cycles apart.
                if (gap_reg != 4'd0) begin
                    gap_next = gap_reg - 4'd1;
                end else if (alu_irq) begin
                    state_next = S_HOLD;
                end else if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (irq_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign irq_pending = (state_reg == S_HOLD);

    // ---------------- ALU pin registers ----------------
    logic             enable_reg;
    logic             enable_a_reg;
    logic             enable_b_reg;
    logic [1:0]       op_a_reg;
    logic [1:0]       op_b_reg;
    logic [7:0]       in_a_reg;
    logic [7:0]       in_b_reg;
    logic             irq_clr_reg;
    logic [CNT_W-1:0] issue_cnt_reg;

    always_ff @(posedge alu_clk) begin
        if (rst) begin
            enable_reg    <= 1'b0;
            enable_a_reg  <= 1'b0;
            enable_b_reg  <= 1'b0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            in_a_reg      <= '0;
            in_b_reg      <= '0;
            irq_clr_reg   <= 1'b0;
            issue_cnt_reg <= '0;
        end else begin
            // Strobes are high only in the cycle following a pop.
            enable_reg   <= pop;
            enable_a_reg <= pop && !head_unit;
            enable_b_reg <= pop && head_unit;
            irq_clr_reg  <= pop && head_clr;
            if (pop) begin
                op_a_reg      <= head_unit ? 2'b00 : head_op;
                op_b_reg      <= head_unit ? head_op : 2'b00;
                in_a_reg      <= head_a;
                in_b_reg      <= head_b;
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
        end
    end

    assign alu_enable   = enable_reg;
    assign alu_enable_a = enable_a_reg;
    assign alu_enable_b = enable_b_reg;
    assign alu_op_a     = op_a_reg;
    assign alu_op_b     = op_b_reg;
    assign alu_in_a     = in_a_reg;
    assign alu_in_b     = in_b_reg;
    assign alu_irq_clr  = irq_clr_reg;
    assign fifo_level   = level_reg;
    assign issue_cnt    = issue_cnt_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Self-checking bench for alu_cmd_sequencer. Two instances: GAP=0 (main) and
// GAP=2 (issue spacing). Expected command order comes from a queue of
// accepted commands; expected counts and timing come from the issue rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    typedef struct packed {
        logic       unit;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       cmd_valid, cmd_ready, cmd_unit, cmd_clr;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr;
    logic [1:0] alu_op_a, alu_op_b;
    logic [7:0] alu_in_a, alu_in_b;
    logic       alu_irq, irq_ack, irq_pending;
    logic [2:0] fifo_level;
    logic [7:0] issue_cnt;

    logic       g_cmd_valid, g_cmd_ready, g_cmd_unit, g_cmd_clr;
    logic [1:0] g_cmd_op;
    logic [7:0] g_cmd_a, g_cmd_b;
    logic       g_alu_enable, g_alu_enable_a, g_alu_enable_b, g_alu_irq_clr;
    logic [1:0] g_alu_op_a, g_alu_op_b;
    logic [7:0] g_alu_in_a, g_alu_in_b;
    logic       g_alu_irq, g_irq_ack, g_irq_pending;
    logic [2:0] g_fifo_level;
    logic [7:0] g_issue_cnt;

    alu_cmd_sequencer #(.DEPTH(4), .GAP(0), .CNT_W(8)) dut (
        .alu_clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_unit(cmd_unit),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_clr(cmd_clr),
        .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_irq_clr(alu_irq_clr), .alu_irq(alu_irq), .irq_ack(irq_ack),
        .irq_pending(irq_pending), .fifo_level(fifo_level), .issue_cnt(issue_cnt)
    );

    alu_cmd_sequencer #(.DEPTH(4), .GAP(2), .CNT_W(8)) dut_g (
        .alu_clk(clk), .rst(rst),
        .cmd_valid(g_cmd_valid), .cmd_ready(g_cmd_ready), .cmd_unit(g_cmd_unit),
        .cmd_op(g_cmd_op), .cmd_a(g_cmd_a), .cmd_b(g_cmd_b), .cmd_clr(g_cmd_clr),
        .alu_enable(g_alu_enable), .alu_enable_a(g_alu_enable_a), .alu_enable_b(g_alu_enable_b),
        .alu_op_a(g_alu_op_a), .alu_op_b(g_alu_op_b), .alu_in_a(g_alu_in_a), .alu_in_b(g_alu_in_b),
        .alu_irq_clr(g_alu_irq_clr), .alu_irq(g_alu_irq), .irq_ack(g_irq_ack),
        .irq_pending(g_irq_pending), .fifo_level(g_fifo_level), .issue_cnt(g_issue_cnt)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   exp_cnt = 0;     // commands expected issued since last reset
    cmd_t exp_q[$];        // accepted commands, in acceptance order
    cmd_t obs_q[$];        // commands seen on the ALU pins
    int   obs_cyc_q[$];
    int   g_cyc_q[$];

    // Issue monitor: one line per issued command.
    always @(negedge clk) begin : monitor
        cmd_t c;
        cyc++;
        if (alu_enable === 1'b1) begin
            c.unit = alu_enable_b;
            c.op   = alu_enable_b ? alu_op_b : alu_op_a;
            c.a    = alu_in_a;
            c.b    = alu_in_b;
            c.clr  = alu_irq_clr;
            obs_q.push_back(c);
            obs_cyc_q.push_back(cyc);
            $display("[%0t] issue cyc=%0d unit=%0d op=%0d a=%02h b=%02h clr=%0d cnt=%0d",
                     $time, cyc, c.unit, c.op, c.a, c.b, c.clr, issue_cnt);
        end
        if (g_alu_enable === 1'b1) begin
            g_cyc_q.push_back(cyc);
            $display("[%0t] gap-dut issue cyc=%0d a=%02h", $time, cyc, g_alu_in_a);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.unit = 1'($urandom_range(0, 1));
        c.op   = 2'($urandom_range(0, 3));
        c.a    = 8'($urandom);
        c.b    = 8'($urandom);
        c.clr  = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // Presents a command and returns just after the edge that accepted it.
    task automatic push_cmd(input cmd_t c);
        int waited = 0;
        {cmd_unit, cmd_op, cmd_a, cmd_b, cmd_clr} = c;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
        end else begin
            tick();
            exp_q.push_back(c);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int w;
        int en_seen;
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
        n_cmp++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, irq_pending} !== 5'b0) begin
            n_err++; $display("FAIL reset_strobes: got %b required 00000", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, irq_pending}); end
        n_cmp++; if ({alu_op_a, alu_op_b, alu_in_a, alu_in_b, issue_cnt} !== 28'h0) begin
            n_err++; $display("FAIL reset_data: got %h required 0", {alu_op_a, alu_op_b, alu_in_a, alu_in_b, issue_cnt}); end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push_cmd(rand_cmd());
        w = 0;
        while (alu_enable !== 1'b1 && w < 20) begin tick(); w++; end
        n_cmp++; if (alu_enable !== 1'b1) begin n_err++; $display("FAIL reset_pre_issue: alu_enable=%b required 1", alu_enable); end
        // Reset lands mid-ISSUE with commands still queued.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete(); g_cyc_q.delete();
        exp_cnt = 0;
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL midreset_level: got %0d required 0", fifo_level); end
        n_cmp++; if ({alu_enable, alu_enable_a, alu_enable_b} !== 3'b0) begin n_err++; $display("FAIL midreset_enables: got %b required 000", {alu_enable, alu_enable_a, alu_enable_b}); end
        n_cmp++; if (issue_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL midreset_cnt: got %0d required %0d", issue_cnt, exp_cnt); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b required 1", cmd_ready); end
        en_seen = 0;
        repeat (6) begin tick(); if (alu_enable === 1'b1) en_seen++; end
        n_cmp++; if (en_seen != 0) begin n_err++; $display("FAIL midreset_discard: %0d issues after reset, required 0", en_seen); end
    endtask

    task automatic test_issue_map();
        cmd_t c;
        c = '{1'b1, 2'd2, 8'h0F, 8'hF0, 1'b1};
        push_cmd(c);
        tick();  // pop edge: pins active in this cycle
        exp_cnt++;
        n_cmp++; if ({alu_enable, alu_enable_a, alu_enable_b} !== 3'b101) begin n_err++; $display("FAIL map_b_enables: got %b required 101", {alu_enable, alu_enable_a, alu_enable_b}); end
        n_cmp++; if ({alu_op_a, alu_op_b} !== 4'b0010) begin n_err++; $display("FAIL map_b_ops: got op_a=%0d op_b=%0d required 0/2", alu_op_a, alu_op_b); end
        n_cmp++; if ({alu_in_a, alu_in_b} !== 16'h0FF0) begin n_err++; $display("FAIL map_b_operands: got %h required 0ff0", {alu_in_a, alu_in_b}); end
        n_cmp++; if (alu_irq_clr !== 1'b1) begin n_err++; $display("FAIL map_b_clr: got %b required 1", alu_irq_clr); end
        n_cmp++; if (issue_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL map_b_cnt: got %0d required %0d", issue_cnt, exp_cnt); end
        tick();
        n_cmp++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr} !== 4'b0) begin n_err++; $display("FAIL map_after_strobes: got %b required 0000", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}); end
        n_cmp++; if ({alu_op_b, alu_in_a, alu_in_b} !== {2'd2, 16'h0FF0}) begin n_err++; $display("FAIL map_after_hold: got %h required held 2/0ff0", {alu_op_b, alu_in_a, alu_in_b}); end
        c = '{1'b0, 2'd3, 8'h55, 8'hAA, 1'b0};
        push_cmd(c);
        tick();
        exp_cnt++;
        n_cmp++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr} !== 4'b1100) begin n_err++; $display("FAIL map_a_strobes: got %b required 1100", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}); end
        n_cmp++; if ({alu_op_a, alu_op_b, alu_in_a, alu_in_b} !== {2'd3, 2'd0, 16'h55AA}) begin n_err++; $display("FAIL map_a_data: got %h required %h", {alu_op_a, alu_op_b, alu_in_a, alu_in_b}, {2'd3, 2'd0, 16'h55AA}); end
        tick();
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_fill();
        cmd_t c5;
        int w;
        alu_irq = 1'b1;
        tick();  // IDLE -> HOLD
        alu_irq = 1'b0;
        n_cmp++; if (irq_pending !== 1'b1) begin n_err++; $display("FAIL fill_hold: irq_pending=%b required 1", irq_pending); end
        for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
        c5 = rand_cmd();
        {cmd_unit, cmd_op, cmd_a, cmd_b, cmd_clr} = c5;
        cmd_valid = 1'b1;
        repeat (3) tick();
        n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL fill_level: got %0d required 4", fifo_level); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL fill_stall: cmd_ready=%b required 0", cmd_ready); end
        irq_ack = 1'b1;
        tick();  // HOLD -> IDLE
        irq_ack = 1'b0;
        n_cmp++; if (irq_pending !== 1'b0) begin n_err++; $display("FAIL fill_release: irq_pending=%b required 0", irq_pending); end
        tick();  // first pop; push refused because FIFO was full at this edge
        n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL fill_pop_nopush: level=%0d required 3", fifo_level); end
        w = 0;
        while (cmd_ready !== 1'b1 && w < 10) begin tick(); w++; end
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back(c5);
        repeat (8) tick();
        exp_cnt += exp_q.size();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL fill_count: issued %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fill_order[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (issue_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL fill_cnt: got %0d required %0d", issue_cnt, exp_cnt); end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_back_to_back();
        alu_irq = 1'b1;
        tick();
        alu_irq = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
        obs_q.delete(); obs_cyc_q.delete();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        repeat (8) tick();
        exp_cnt += exp_q.size();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: issued %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 1; i < obs_cyc_q.size(); i++) begin
            n_cmp++; if (obs_cyc_q[i] != obs_cyc_q[i-1] + 1) begin n_err++; $display("FAIL b2b_spacing[%0d]: gap %0d cycles required 1", i, obs_cyc_q[i] - obs_cyc_q[i-1]); end
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_order[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (issue_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL b2b_cnt: got %0d required %0d", issue_cnt, exp_cnt); end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_gap();
        cmd_t c;
        int n_push = 3;
        g_alu_irq = 1'b1;
        tick();
        g_alu_irq = 1'b0;
        for (int i = 0; i < n_push; i++) begin
            c = rand_cmd();
            {g_cmd_unit, g_cmd_op, g_cmd_a, g_cmd_b, g_cmd_clr} = c;
            g_cmd_valid = 1'b1;
            tick();
        end
        g_cmd_valid = 1'b0;
        n_cmp++; if (g_fifo_level !== 3'(n_push)) begin n_err++; $display("FAIL gap_level: got %0d required %0d", g_fifo_level, n_push); end
        g_cyc_q.delete();
        g_irq_ack = 1'b1;
        tick();
        g_irq_ack = 1'b0;
        repeat (15) tick();
        n_cmp++; if (g_cyc_q.size() != n_push) begin n_err++; $display("FAIL gap_count: issued %0d required %0d", g_cyc_q.size(), n_push); end
        for (int i = 1; i < g_cyc_q.size(); i++) begin
            n_cmp++; if (g_cyc_q[i] - g_cyc_q[i-1] != 2 + 1) begin n_err++; $display("FAIL gap_spacing[%0d]: %0d cycles required 3", i, g_cyc_q[i] - g_cyc_q[i-1]); end
        end
        n_cmp++; if (g_issue_cnt !== 8'(n_push)) begin n_err++; $display("FAIL gap_cnt: got %0d required %0d", g_issue_cnt, n_push); end
    endtask

    task automatic test_irq();
        alu_irq = 1'b1;
        tick();
        alu_irq = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(rand_cmd());
        obs_q.delete(); obs_cyc_q.delete();
        irq_ack = 1'b1;
        tick();  // HOLD -> IDLE
        irq_ack = 1'b0;
        tick();  // cmd 1 issuing
        n_cmp++; if (alu_enable !== 1'b1) begin n_err++; $display("FAIL irq_cmd1: alu_enable=%b required 1", alu_enable); end
        tick();  // cmd 2 issuing; ALU now signals the interrupt raised by cmd 1
        alu_irq = 1'b1;
        tick();
        n_cmp++; if ({irq_pending, alu_enable} !== 2'b10) begin n_err++; $display("FAIL irq_hold: pending/enable=%b required 10", {irq_pending, alu_enable}); end
        n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL irq_level: got %0d required 1", fifo_level); end
        irq_ack = 1'b1;  // acknowledged while alu_irq still high
        tick();
        irq_ack = 1'b0;
        n_cmp++; if (irq_pending !== 1'b0) begin n_err++; $display("FAIL irq_ack_release: pending=%b required 0", irq_pending); end
        tick();
        n_cmp++; if ({irq_pending, fifo_level} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL irq_reenter: pending=%b level=%0d required 1/1", irq_pending, fifo_level); end
        alu_irq = 1'b0;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();
        n_cmp++; if (alu_enable !== 1'b1) begin n_err++; $display("FAIL irq_cmd3: alu_enable=%b required 1", alu_enable); end
        tick();
        exp_cnt += exp_q.size();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL irq_count: issued %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL irq_order[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (issue_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL irq_cnt: got %0d required %0d", issue_cnt, exp_cnt); end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_wrap();
        int w;
        int n_total = 257;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
        for (int i = 0; i < n_total; i++) begin
            push_cmd(rand_cmd());
            repeat ($urandom_range(0, 3)) tick();
        end
        w = 0;
        while (obs_q.size() < n_total && w < 100) begin tick(); w++; end
        tick();
        exp_cnt = exp_q.size();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL wrap_count: issued %0d required %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_order[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (issue_cnt !== 8'(exp_cnt % 256)) begin n_err++; $display("FAIL wrap_cnt: got %0d required %0d", issue_cnt, exp_cnt % 256); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL wrap_level: got %0d required 0", fifo_level); end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_unit = 1'b0; cmd_op = 2'd0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_clr = 1'b0;
        alu_irq = 1'b0; irq_ack = 1'b0;
        g_cmd_valid = 1'b0; g_cmd_unit = 1'b0; g_cmd_op = 2'd0; g_cmd_a = 8'd0; g_cmd_b = 8'd0; g_cmd_clr = 1'b0;
        g_alu_irq = 1'b0; g_irq_ack = 1'b0;
        test_reset();
        test_issue_map();
        test_fill();
        test_back_to_back();
        test_gap();
        test_irq();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
